// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// wait-stated memory handshake and bus timeout. Define CTRL_CBNZ_EN to decode CBNZ.
module multicycle_control #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        ir_write,
  output logic        pc_write,
  output logic        Reg2Loc,
  output logic        ALUSrc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        Branch,
  output logic [1:0]  ALUOp,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB_R, S_WB_L, S_TRAP, S_ERR
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE, CLS_R, CLS_LDUR, CLS_STUR, CLS_CBZ, CLS_CBNZ, CLS_ILL
  } cls_t;

  state_t           state;
  cls_t             cls;
  cls_t             dec;
  logic [CNT_W-1:0] wait_cnt;
  logic             in_mem_phase;
  logic             timeout_hit;

  function automatic cls_t decode(input logic [10:0] op);
    cls_t c;
    case (op)
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: c = CLS_R;
      11'b11111000010: c = CLS_LDUR;
      11'b11111000000: c = CLS_STUR;
      default: begin
        if (op[10:3] == 8'b10110100)
          c = CLS_CBZ;
`ifdef CTRL_CBNZ_EN
        else if (op[10:3] == 8'b10110101)
          c = CLS_CBNZ;
`endif
        else
          c = CLS_ILL;
      end
    endcase
    return c;
  endfunction

  always_comb begin
    dec          = decode(opcode);
    in_mem_phase = (state == S_FETCH) || (state == S_MEM);
    // Timeout only fires when the final allowed wait cycle also sees no ready.
    timeout_hit  = (wait_cnt == CNT_W'(TIMEOUT - 1)) && !mem_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      cls      <= CLS_NONE;
      wait_cnt <= '0;
    end else begin
      wait_cnt <= (in_mem_phase && !mem_ready) ? wait_cnt + 1'b1 : '0;
      case (state)
        S_FETCH: begin
          if (mem_ready)        state <= S_DECODE;
          else if (timeout_hit) state <= S_ERR;
        end
        S_DECODE: begin
          cls   <= dec;
          state <= (dec == CLS_ILL) ? S_TRAP : S_EXEC;
        end
        S_EXEC: begin
          case (cls)
            CLS_R:              state <= S_WB_R;
            CLS_LDUR, CLS_STUR: state <= S_MEM;
            default:            state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (mem_ready)        state <= (cls == CLS_LDUR) ? S_WB_L : S_FETCH;
          else if (timeout_hit) state <= S_ERR;
        end
        S_WB_R, S_WB_L: state <= S_FETCH;
        default:        state <= state;
      endcase
    end
  end

  // Moore decode of the registered state; ir/pc strobes follow mem_ready in FETCH.
  always_comb begin
    mem_req  = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    Reg2Loc  = 1'b0;
    ALUSrc   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    Branch   = 1'b0;
    ALUOp    = 2'b00;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req  = 1'b1;
          MemRead  = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_DECODE: Reg2Loc = (dec == CLS_STUR) || (dec == CLS_CBZ) || (dec == CLS_CBNZ);
        S_EXEC: begin
          case (cls)
            CLS_R: ALUOp = 2'b10;
            CLS_LDUR, CLS_STUR: ALUSrc = 1'b1;
            CLS_CBZ, CLS_CBNZ: begin
              Reg2Loc = 1'b1;
              ALUOp   = 2'b01;
              Branch  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          ALUSrc  = 1'b1;
          mem_req = 1'b1;
          if (cls == CLS_LDUR) begin
            MemRead = 1'b1;
          end else begin
            Reg2Loc  = 1'b1;
            MemWrite = 1'b1;
          end
        end
        S_WB_R: RegWrite = 1'b1;
        S_WB_L: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_TRAP: illegal = 1'b1;
        S_ERR:  bus_err = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: each instruction is expanded into its
// expected per-cycle control words from the instruction-class rules.
module tb_multicycle_control;

  localparam int TIMEOUT = 16;

  localparam int REQ = 13, IRW = 12, PCW = 11, R2L = 10, ASRC = 9, M2R = 8,
                 RW = 7, MR = 6, MW = 5, BR = 4, ILL = 1, BE = 0;

  localparam int K_R = 0, K_LDUR = 1, K_STUR = 2, K_CBZ = 3, K_CBNZ = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] opcode;
  logic        mem_ready;
  logic        mem_req, ir_write, pc_write, Reg2Loc, ALUSrc, MemtoReg, RegWrite;
  logic        MemRead, MemWrite, Branch, illegal, bus_err;
  logic [1:0]  ALUOp;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(mem_req), .ir_write(ir_write), .pc_write(pc_write),
    .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .Branch(Branch), .ALUOp(ALUOp), .illegal(illegal), .bus_err(bus_err)
  );

  wire [13:0] outs = {mem_req, ir_write, pc_write, Reg2Loc, ALUSrc, MemtoReg,
                      RegWrite, MemRead, MemWrite, Branch, ALUOp, illegal, bus_err};

  task automatic check(input string tag, input logic [13:0] got, input logic [13:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%b exp=%b at %0t", tag, got, exp, $time);
  endtask

  // One clock: drive inputs just after the edge, compare at the falling edge.
  task automatic step(input string tag, input logic r, input logic [10:0] op,
                      input logic rs, input logic [13:0] exp);
    rst = rs; mem_ready = r; opcode = op;
    @(negedge clk);
    check(tag, outs, exp);
    @(posedge clk); #1;
  endtask

  function automatic int classify(input logic [10:0] op);
    if (op == 11'h458 || op == 11'h658 || op == 11'h450 || op == 11'h550) return K_R;
    if (op == 11'h7C2) return K_LDUR;
    if (op == 11'h7C0) return K_STUR;
    if ((op >> 3) == 11'd180) return K_CBZ;
`ifdef CTRL_CBNZ_EN
    if ((op >> 3) == 11'd181) return K_CBNZ;
`endif
    return K_ILL;
  endfunction

  function automatic logic [10:0] junk();
    return 11'($urandom);
  endfunction

  task automatic do_reset();
    for (int i = 0; i < 2; i++) step("reset", 1'($urandom), junk(), 1'b1, '0);
  endtask

  task automatic hold_flag(input string tag, input int bitpos);
    logic [13:0] e;
    e = '0; e[bitpos] = 1'b1;
    for (int i = 0; i < 3; i++) step(tag, 1'($urandom), junk(), 1'b0, e);
    do_reset();
  endtask

  // Memory phase with 'waits' stall cycles; returns 0 if it ended in a bus error.
  task automatic mem_phase(input string tag, input logic [13:0] base, input int waits,
                           input logic [13:0] done_extra, output bit ok);
    int n;
    n = (waits < TIMEOUT) ? waits : TIMEOUT;
    for (int i = 0; i < n; i++) step(tag, 1'b0, junk(), 1'b0, base);
    if (waits >= TIMEOUT) begin
      hold_flag("bus_err", BE);
      ok = 0;
    end else begin
      step(tag, 1'b1, junk(), 1'b0, base | done_extra);
      ok = 1;
    end
  endtask

  task automatic run_instr(input logic [10:0] op, input int fw, input int mw, input bit abort);
    logic [13:0] e, f;
    int k;
    bit ok;
    k = classify(op);
    f = '0; f[REQ] = 1; f[MR] = 1;
    e = '0; e[IRW] = 1; e[PCW] = 1;
    mem_phase("fetch", f, fw, e, ok);
    if (!ok) return;
    e = '0; e[R2L] = (k == K_STUR || k == K_CBZ || k == K_CBNZ);
    step("decode", 1'($urandom), op, 1'b0, e);
    if (k == K_ILL) begin
      hold_flag("trap", ILL);
      return;
    end
    e = '0;
    if (k == K_R) e[3:2] = 2'b10;
    else if (k == K_LDUR || k == K_STUR) e[ASRC] = 1;
    else begin e[R2L] = 1; e[3:2] = 2'b01; e[BR] = 1; end
    step("exec", 1'($urandom), junk(), 1'b0, e);
    if (k == K_R) begin
      e = '0; e[RW] = 1;
      step("wb_r", 1'($urandom), junk(), 1'b0, e);
    end else if (k == K_LDUR || k == K_STUR) begin
      f = '0; f[ASRC] = 1; f[REQ] = 1;
      if (k == K_LDUR) f[MR] = 1; else begin f[R2L] = 1; f[MW] = 1; end
      if (abort) begin
        for (int i = 0; i < mw; i++) step("mem_wait", 1'b0, junk(), 1'b0, f);
        do_reset();
        return;
      end
      mem_phase("mem", f, mw, '0, ok);
      if (ok && k == K_LDUR) begin
        e = '0; e[M2R] = 1; e[RW] = 1;
        step("wb_l", 1'($urandom), junk(), 1'b0, e);
      end
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 16) return r % 4;
    if (r < 18) return TIMEOUT - 1;
    return TIMEOUT;
  endfunction

  function automatic logic [10:0] pick_op();
    logic [10:0] tbl [0:5];
    int r;
    tbl = '{11'h458, 11'h658, 11'h450, 11'h550, 11'h7C2, 11'h7C0};
    r = $urandom_range(0, 9);
    if (r < 6) return tbl[r];
    if (r == 6) return {8'hB4, 3'($urandom)};
    if (r == 7) return {8'hB5, 3'($urandom)};
    return 11'($urandom);
  endfunction

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = '0;
    @(posedge clk); #1;
    do_reset();
    run_instr(11'b10001011000, 0, 0, 0);   // ADD, no waits
    run_instr(11'b11111000010, 0, 3, 0);   // LDUR, 3 data waits
    run_instr(11'b10001011000, TIMEOUT, 0, 0);      // fetch timeout
    run_instr(11'b10001011000, TIMEOUT - 1, 0, 0);  // ready on last wait cycle
    run_instr(11'b10110101000, 0, 0, 0);   // CBNZ pattern
    run_instr(11'b11111000000, 0, 1, 0);   // STUR then CBZ
    run_instr(11'b10110100011, 0, 0, 0);
    run_instr(11'b11111000010, 1, TIMEOUT, 0);      // data timeout
    run_instr(11'b11111000010, 0, 2, 1);   // reset mid data wait
    run_instr(11'b11001011000, 2, 0, 0);
    for (int i = 0; i < 200; i++)
      run_instr(pick_op(), pick_wait(), pick_wait(), ($urandom_range(0, 15) == 0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
